// File: rtl/fetch_queue_if.sv
`timescale 1ns/1ps
// fetch_queue_if
//
// Bundles the instruction-bus handshake, the decode-side pop handshake and
// the redirect inputs of the instruction prefetch queue.
//
// Signals:
//   ireq           ibus request: valid + 64-bit addr (driven by fetch_queue)
//   iresp          ibus response: data_ok + 32-bit data (driven by the bus)
//   out_valid      head entry available to decode (driven by fetch_queue)
//   out_ready      decode accepts the head this cycle (driven by decode)
//   out_pc         PC of the head entry
//   out_instr      instruction word of the head entry
//   redirect_valid discard all fetched/in-flight work and restart
//   redirect_pc    restart address, low two bits ignored
//
// Modports:
//   master  the fetch_queue view
//   slave   the environment view (ibus, decode, branch unit)
interface fetch_queue_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  ibus_req_t   ireq;
  ibus_resp_t  iresp;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output ireq,
    input  iresp,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  ireq,
    output iresp,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue
//
// Instruction-fetch front end for the five-stage RV64 core. Keeps a
// DEPTH-entry circular prefetch queue of {pc, instr} pairs filled from a
// blocking instruction bus with at most one request outstanding, and
// supports redirects that may land while a request is still on the bus.
//
// Parameters:
//   DEPTH     queue entries, power of two, at least 2
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous reset, active low (asserted at 0)
//   bus      fetch_queue_if.master: ibus request/response, decode pop
//            handshake and redirect inputs
//   count_o  current queue occupancy
//
// Optional feature (compile-time macro FETCHQ_BYPASS_EN):
//   When defined, a response arriving while the queue is empty, the FSM is
//   in RUN and no redirect is present is shown combinationally on the
//   decode outputs in the same cycle. If decode takes it, it is never
//   written into the queue. When undefined, every response is written
//   first and reaches decode one cycle later at the earliest.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_queue_if.master            bus,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  // RUN fetches normally; KILL waits out a request made stale by a redirect.
  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic [63:0]     reqAddr_q, reqAddr_d;
  logic [63:0]     fetchPc_q, fetchPc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [63:0]     pcMem    [DEPTH];
  logic [31:0]     instrMem [DEPTH];

  logic            respAccept;
  logic            bypassHit;
  logic            bypassTake;
  logic            pushEntry;
  logic            popEntry;
  logic            launchReq;
  logic [63:0]     redirectTarget;
  logic            unusedRedirectLsbs;

  // Redirect targets are word aligned; the two low bits never reach fetchPc.
  assign redirectTarget     = {bus.redirect_pc[63:2], 2'b00};
  assign unusedRedirectLsbs = ^bus.redirect_pc[1:0];

  // A response only counts while our own request is on the bus.
  assign respAccept = busy_q & bus.iresp.data_ok;

  // The request register is the bus request: valid and addr stay frozen
  // until data_ok because nothing below changes them while busy_q is set.
  assign bus.ireq = {busy_q, reqAddr_q};

  assign count_o = count_q;

`ifdef FETCHQ_BYPASS_EN
  // Empty queue and a live response: hand it straight to decode.
  assign bypassHit = respAccept && (state_q == RUN) && !bus.redirect_valid &&
                     (count_q == '0);
`else
  assign bypassHit = 1'b0;
`endif

  assign bypassTake = bypassHit & bus.out_ready;

  // Decode outputs: the bypassed response takes priority over the (empty)
  // head slot; a redirect always hides the head so nothing stale is popped.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_pc    = pcMem[head_q];
    bus.out_instr = instrMem[head_q];
    if (bypassHit) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = reqAddr_q;
      bus.out_instr = bus.iresp.data;
    end else if ((count_q != '0) && !bus.redirect_valid) begin
      bus.out_valid = 1'b1;
    end
  end

  // A bypassed response is not a queue pop; the head only moves for entries
  // that were actually stored.
  assign popEntry  = bus.out_valid & bus.out_ready & ~bypassHit;

  // Responses in KILL or in a redirect cycle are stale and dropped.
  assign pushEntry = respAccept & (state_q == RUN) & ~bus.redirect_valid &
                     ~bypassTake;

  // One request outstanding and launch only with a free slot, so every
  // response is guaranteed a place in the queue.
  assign launchReq = (state_q == RUN) & ~busy_q & (count_q < FullCount);

  // Next-state logic. Redirect overrides everything: the queue is emptied,
  // fetchPc moves to the target, and the FSM either waits out a busy
  // request in KILL or launches the target immediately when the bus is
  // free (or becomes free this very cycle).
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    reqAddr_d = reqAddr_q;
    fetchPc_d = fetchPc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (bus.redirect_valid) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      fetchPc_d = redirectTarget;
      if (busy_q && !bus.iresp.data_ok) begin
        state_d = KILL;
      end else begin
        state_d   = RUN;
        busy_d    = 1'b1;
        reqAddr_d = redirectTarget;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (respAccept) begin
            busy_d    = 1'b0;
            fetchPc_d = fetchPc_q + 64'd4;
          end else if (launchReq) begin
            busy_d    = 1'b1;
            reqAddr_d = fetchPc_q;
          end

          if (pushEntry) begin
            tail_d = tail_q + 1'b1;
          end
          if (popEntry) begin
            head_d = head_q + 1'b1;
          end

          if (pushEntry && !popEntry) begin
            count_d = count_q + 1'b1;
          end else if (!pushEntry && popEntry) begin
            count_d = count_q - 1'b1;
          end
        end

        KILL: begin
          if (respAccept) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Control state. Reset abandons any in-flight request at once: busy_q
  // drops asynchronously so ireq.valid falls without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      busy_q    <= 1'b0;
      reqAddr_q <= RESET_PC;
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      reqAddr_q <= reqAddr_d;
      fetchPc_q <= fetchPc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Queue storage needs no reset: count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (pushEntry) begin
      pcMem[tail_q]    <= reqAddr_q;
      instrMem[tail_q] <= bus.iresp.data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// tb_fetch_queue
//
// Directed bench for fetch_queue. Stimulus tasks push the {pc, instr} pairs
// decode should see into a scoreboard queue; a separate monitor pops and
// compares on every accepted decode handshake. A bus model answers each
// request in the cycle it is first seen, up to a response budget the
// stimulus grants, and returns addr[31:0] + 32'h13 as the instruction.
module tb_fetch_queue;

  localparam int          Depth   = 4;
  localparam logic [63:0] ResetPc = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic                    clk;
  logic                    reset;
  logic [$clog2(Depth):0]  count;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (Depth),
    .RESET_PC (ResetPc)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .count_o (count)
  );

  int     testsRun    = 0;
  int     testsFailed = 0;
  int     busGiven    = 0;
  int     busLimit    = 0;
  entry_t expQ[$];

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Bus model: responds at the negedge of the first cycle a request is
  // visible, as long as the granted budget is not used up.
  initial begin
    bus.iresp.data_ok = 1'b0;
    bus.iresp.data    = '0;
    forever begin
      @(negedge clk);
      if (reset && bus.ireq.valid && (busGiven < busLimit)) begin
        bus.iresp.data_ok = 1'b1;
        bus.iresp.data    = bus.ireq.addr[31:0] + 32'h13;
        busGiven++;
      end else begin
        bus.iresp.data_ok = 1'b0;
        bus.iresp.data    = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard monitor, sampling mid low phase after all stimulus settles.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset && bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL sb_unexpected: got pc %h, expected no entry",
                   bus.out_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_pc", bus.out_pc, e.pc);
          checkOutput("sb_instr", 64'(bus.out_instr), 64'(e.instr));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic giveResponses(input int n);
    busLimit = busGiven + n;
  endtask

  task automatic pushExp(input logic [63:0] pc, input logic [31:0] instr);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    expQ.push_back(e);
  endtask

  task automatic waitReq(input logic [63:0] target, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ireq.valid && (bus.ireq.addr == target)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, {63'b0, seen}, 64'd1);
  endtask

  task automatic applyReset();
    reset              = 1'b0;
    busLimit           = busGiven;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    tick();
    tick();
  endtask

  // Reset values, then a streaming fetch with decode always ready.
  task automatic testStream();
    int maxCount = 0;
    applyReset();
    checkOutput("rst_ireq_valid", 64'(bus.ireq.valid), 64'd0);
    checkOutput("rst_ireq_addr", bus.ireq.addr, 64'h8000_0000);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);

    bus.out_ready = 1'b1;
    giveResponses(3);
    pushExp(64'h8000_0000, 32'h8000_0013);
    pushExp(64'h8000_0004, 32'h8000_0017);
    pushExp(64'h8000_0008, 32'h8000_001B);
    reset = 1'b1;
    tick();
    checkOutput("first_req_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("first_req_addr", bus.ireq.addr, 64'h8000_0000);
`ifdef FETCHQ_BYPASS_EN
    checkOutput("bypass_same_cycle", 64'(bus.out_valid), 64'd1);
`else
    checkOutput("resp_latency", 64'(bus.out_valid), 64'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      if (int'(count) > maxCount) maxCount = int'(count);
      tick();
    end
`ifdef FETCHQ_BYPASS_EN
    checkOutput("t1_max_count", 64'(maxCount), 64'd0);
`else
    checkOutput("t1_max_count", 64'(maxCount), 64'd1);
`endif
    checkOutput("t1_drained", 64'(expQ.size()), 64'd0);
    checkOutput("t1_next_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("t1_next_addr", bus.ireq.addr, 64'h8000_000C);
  endtask

  // Fill the queue with decode stalled, then pop once to release a launch.
  task automatic testFull();
    applyReset();
    giveResponses(4);
    pushExp(64'h8000_0000, 32'h8000_0013);
    pushExp(64'h8000_0004, 32'h8000_0017);
    pushExp(64'h8000_0008, 32'h8000_001B);
    pushExp(64'h8000_000C, 32'h8000_001F);
    reset = 1'b1;
    repeat (12) tick();
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_no_launch", 64'(bus.ireq.valid), 64'd0);
    tick();
    tick();
    checkOutput("full_no_launch_late", 64'(bus.ireq.valid), 64'd0);

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("pop_launch_wait", 64'(bus.ireq.valid), 64'd0);
    tick();
    checkOutput("pop_launch_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("pop_launch_addr", bus.ireq.addr, 64'h8000_0010);
    checkOutput("pop_count", 64'(count), 64'd3);

    bus.out_ready = 1'b1;
    repeat (5) tick();
    checkOutput("t2_drained", 64'(expQ.size()), 64'd0);
    checkOutput("t2_count", 64'(count), 64'd0);
  endtask

  // Redirect while a request is stuck on the bus: hold it, drop its data.
  task automatic testKill();
    applyReset();
    bus.out_ready = 1'b1;
    giveResponses(2);
    pushExp(64'h8000_0000, 32'h8000_0013);
    pushExp(64'h8000_0004, 32'h8000_0017);
    reset = 1'b1;
    waitReq(64'h8000_0008, "kill_setup_req");
    tick();
    tick();
    checkOutput("kill_setup_drained", 64'(expQ.size()), 64'd0);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1002;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("kill_hold_valid", 64'(bus.ireq.valid), 64'd1);
      checkOutput("kill_hold_addr", bus.ireq.addr, 64'h8000_0008);
      checkOutput("kill_count", 64'(count), 64'd0);
      if (i < 2) tick();
    end

    giveResponses(2);
    pushExp(64'h8000_1000, 32'h8000_1013);
    waitReq(64'h8000_1000, "kill_target_req");
    checkOutput("kill_target_addr", bus.ireq.addr, 64'h8000_1000);
    repeat (4) tick();
    checkOutput("t3_drained", 64'(expQ.size()), 64'd0);
  endtask

  // Redirect, response and pop all in the same cycle.
  task automatic testRedirectPop();
    applyReset();
    giveResponses(2);
    reset = 1'b1;
    waitReq(64'h8000_0004, "rp_setup_req");
    checkOutput("rp_pre_out_valid", 64'(bus.out_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    bus.out_ready      = 1'b1;
    #1;
    checkOutput("rp_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    checkOutput("rp_count", 64'(count), 64'd0);
    checkOutput("rp_next_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("rp_next_addr", bus.ireq.addr, 64'h8000_2000);
    giveResponses(1);
    pushExp(64'h8000_2000, 32'h8000_2013);
    repeat (4) tick();
    checkOutput("t4_drained", 64'(expQ.size()), 64'd0);
  endtask

  // Asynchronous reset in the middle of a request with a non-empty queue.
  task automatic testAsyncReset();
    bus.out_ready = 1'b0;
    giveResponses(1);
    repeat (4) tick();
    checkOutput("ar_pre_count", 64'(count), 64'd1);
    checkOutput("ar_pre_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("ar_pre_out_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("ar_ireq_valid", 64'(bus.ireq.valid), 64'd0);
    checkOutput("ar_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("ar_count", 64'(count), 64'd0);
    tick();
    busLimit = busGiven;
    tick();
    bus.out_ready = 1'b1;
    giveResponses(1);
    pushExp(64'h8000_0000, 32'h8000_0013);
    reset = 1'b1;
    tick();
    checkOutput("ar_restart_valid", 64'(bus.ireq.valid), 64'd1);
    checkOutput("ar_restart_addr", bus.ireq.addr, 64'h8000_0000);
    repeat (4) tick();
    checkOutput("t5_drained", 64'(expQ.size()), 64'd0);
  endtask

  task automatic applyStimulus();
    testStream();
    testFull();
    testKill();
    testRedirectPop();
    testAsyncReset();
  endtask

  initial begin
    reset              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the five-stage RV64 core. It replaces the single-instruction fetch register with a DEPTH-entry prefetch queue. It drives the blocking instruction bus ahead of decode and supports redirects that can land while a bus request is in flight. It sits between the ibus port and decode: decode pops `{pc, instr}` pairs, and execute/branch logic issues redirects.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `RESET_PC`, default 64'h8000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `ireq`  out  ibus_req_t  uses `ireq.valid` and `ireq.addr` (64 b).
- `iresp`  in  ibus_resp_t  uses `iresp.data_ok` and `iresp.data` (32 b).
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  64  PC of head entry.
- `out_instr`  out  32  instruction of head entry.
- `redirect_valid`  in  1  discard all fetched/in-flight work and restart.
- `redirect_pc`  in  64  restart address; bits [1:0] are ignored and treated as 0.
- `count`  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus `count`. Entries hold `{pc, instr}`.
- Fetch PC `fpc` is 64 b and increments by 4 after each accepted response; wrap at 2^64 is natural.
- Bus rule: once `ireq.valid` rises, `ireq.valid` and `ireq.addr` are held stable until the cycle `iresp.data_ok`=1. There is at most one outstanding request.
- New request launch condition: state RUN, no request busy, and `count` < DEPTH. Because only one request is outstanding and launch needs space, a response always fits.
- FSM states:
  - RUN: normal prefetch. On `data_ok`, push `{ireq.addr, iresp.data}` and set `fpc`+=4.
  - KILL: a stale request is still on the bus. Hold it. On `data_ok`, drop the data and return to RUN.
- Redirect, in any state:
  - Clear the queue (count←0, head=tail).
  - `fpc`←`redirect_pc` with bits [1:0] forced to 00.
  - If a request is busy and `data_ok`=0 this cycle, go to KILL. Otherwise stay in, or go to, RUN.
  - A response arriving in the redirect cycle is discarded.
- Redirect while in KILL: update `fpc` and remain in KILL.
- Pop: `out_valid & out_ready` advances head.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Simultaneous redirect and pop: redirect wins and the pop is ignored.
- `out_valid` is forced to 0 in any cycle with `redirect_valid`=1.
- `out_pc` and `out_instr` are don't-care when `out_valid`=0.

## Timing
- Reset asserted: `ireq.valid`=0, `ireq.addr`=RESET_PC, `out_valid`=0, `count`=0, state RUN, `fpc`=RESET_PC.
- Reset mid-request: the request is abandoned immediately, and the response is never consumed.
- First clock edge after reset release: `ireq.valid`=1 with `ireq.addr`=RESET_PC.
- Response at cycle t, queue empty: `out_valid`=1 at t+1.
- Back-to-back fetch: the next request launches in the cycle after `data_ok`. With a 1-cycle bus, the peak rate is 1 instruction per 2 cycles.
- Redirect at t with no busy request: `ireq.valid`=1 with `ireq.addr`=`redirect_pc` at t+1.
- Redirect at t with a busy request: the target is requested in the cycle after the stale `data_ok`.
- Full queue (count=DEPTH): no launch. The launch occurs in the cycle after the first pop.

## Configuration
- `FETCHQ_BYPASS_EN` defined: when count=0, state RUN, no redirect, and `data_ok`=1, the response is presented combinationally on `out_*` with `out_valid`=1 in the same cycle.
  - If `out_ready`=1, the entry is consumed without being written.
  - If `out_ready`=0, it is pushed normally.
- `FETCHQ_BYPASS_EN` undefined: responses are always written first, giving a minimum response-to-`out_valid` latency of 1 cycle.

## Test plan
- Reset release, 1-cycle bus returning 32'h00000013, `out_ready`=1 → first `ireq.addr`=8000_0000. Decode sees pc 8000_0000, 8000_0004, 8000_0008 in order, with `count` ≤1.
- `out_ready`=0 with DEPTH=4 → exactly 4 responses accepted, `count`=4, and `ireq.valid` stays 0. One pop leads to a new request with addr 8000_0010.
- Redirect to 8000_1002 while request 8000_0008 is pending for 3 cycles → state KILL and `ireq.addr` held at 8000_0008. Its data is dropped, the next request is 8000_1000, and `count`=0 throughout.
- Redirect in the same cycle as `data_ok` and a pop → queue empty, response dropped, next `ireq.addr`=redirect target, and `out_valid`=0 in that cycle.
- Reset asserted asynchronously mid-request → `ireq.valid` and `out_valid` fall without a clock edge. After release, fetch restarts at 8000_0000.
- With `FETCHQ_BYPASS_EN` defined and the queue empty → `out_valid`=1 in the same cycle as `data_ok`, and `count` stays 0 when `out_ready`=1.
